// File: rtl/norm_shift_if.sv
// Handshake and payload bundle for the normalization shifter.
interface norm_shift_if #(
  parameter int unsigned W    = 56,
  parameter int unsigned EW   = 13,
  parameter int unsigned TAGW = 4
) ();
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    fr;
  logic [EW-1:0]   er;
  logic [EW-1:0]   sh;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    fn;
  logic [EW-1:0]   en;
  logic [TAGW-1:0] out_tag;
  logic            fn_zero;

  // Upstream/downstream side: drives operands and out_ready.
  modport master (
    output in_valid, fr, er, sh, in_tag, out_ready,
    input  in_ready, out_valid, fn, en, out_tag, fn_zero
  );

  // Shifter side.
  modport slave (
    input  in_valid, fr, er, sh, in_tag, out_ready,
    output in_ready, out_valid, fn, en, out_tag, fn_zero
  );
endinterface

// File: rtl/norm_shift.sv
// Normalization shifter: 2-stage signed shift of the significand with sticky,
// exponent adjust en = er - sh, valid/ready pipeline at one op per cycle.
module norm_shift #(
  parameter int unsigned W    = 56,
  parameter int unsigned EW   = 13,
  parameter int unsigned TAGW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  norm_shift_if.slave bus
);

  localparam int unsigned MW = EW + 1;  // magnitude holds 2^(EW-1)
  localparam int unsigned CW = 6;       // coarse shift amount width (8*mag[5:3])
  localparam int unsigned FW = 3;       // fine shift amount width

  // Stage 1 registers
  logic            r_v1;
  logic [W-1:0]    r_val;
  logic            r_sticky;
  logic            r_dir;
  logic [FW-1:0]   r_fine;
  logic [EW-1:0]   r_en;
  logic [TAGW-1:0] r_tag;

  // Stage 2 (output) registers
  logic            r_v2;
  logic [W-1:0]    r_fn;
  logic [EW-1:0]   r_en2;
  logic [TAGW-1:0] r_tag2;
  logic            r_fn_zero;

  logic            w_r1;
  logic            w_r2;
  logic            w_dir;
  logic [MW-1:0]   w_sh_ext;
  logic [MW-1:0]   w_mag;
  logic            w_sat;
  logic [CW-1:0]   w_csh;
  logic [W-1:0]    w_cval;
  logic            w_csticky;
  logic [W-1:0]    w_fmask;
  logic            w_fsticky;
  logic [W-1:0]    w_fn;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_r2         = ~r_v2 | bus.out_ready;
  assign w_r1         = ~r_v1 | w_r2;
  assign bus.in_ready = w_r1;

  assign bus.out_valid = r_v2;
  assign bus.fn        = r_fn;
  assign bus.en        = r_en2;
  assign bus.out_tag   = r_tag2;
  assign bus.fn_zero   = r_fn_zero;

  // Stage 1 datapath: direction, magnitude, saturation and byte-granular shift.
  always_comb begin
    w_dir     = bus.sh[EW-1];
    w_sh_ext  = {bus.sh[EW-1], bus.sh};
    w_mag     = w_dir ? MW'(-w_sh_ext) : w_sh_ext;
    w_sat     = (w_mag >= MW'(W));
    w_csh     = {w_mag[5:3], 3'b000};
    w_cval    = '0;
    w_csticky = 1'b0;
    if (w_sat) begin
      w_csticky = w_dir & (|bus.fr);
    end else if (w_dir) begin
      w_cval    = bus.fr >> w_csh;
      w_csticky = |(bus.fr & ~({W{1'b1}} << w_csh));
    end else begin
      w_cval    = bus.fr << w_csh;
    end
  end

  // Stage 1 register: capture coarse result and sideband on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_val    <= '0;
      r_sticky <= 1'b0;
      r_dir    <= 1'b0;
      r_fine   <= '0;
      r_en     <= '0;
      r_tag    <= '0;
    end else if (w_r1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_val    <= w_cval;
        r_sticky <= w_csticky;
        r_dir    <= w_dir;
        r_fine   <= w_mag[FW-1:0];
        r_en     <= bus.er - bus.sh;
        r_tag    <= bus.in_tag;
      end
    end
  end

  // Stage 2 datapath: bit-granular shift and sticky fold into the LSB.
  always_comb begin
    w_fmask   = ~({W{1'b1}} << r_fine);
    w_fsticky = r_sticky | (|(r_val & w_fmask));
    w_fn      = r_val << r_fine;
    if (r_dir) begin
      w_fn = (r_val >> r_fine) | W'(w_fsticky);
    end
  end

  // Stage 2 register: output hold while stalled, reload when drained or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_fn      <= '0;
      r_en2     <= '0;
      r_tag2    <= '0;
      r_fn_zero <= 1'b0;
    end else if (w_r2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_fn      <= w_fn;
        r_en2     <= r_en;
        r_tag2    <= r_tag;
        r_fn_zero <= (w_fn == '0);
      end
    end
  end

endmodule

// File: tb/tb_norm_shift.sv
// Bench for norm_shift: queue scoreboard against an arithmetic reference model.
module tb_norm_shift;
  localparam int unsigned W    = 56;
  localparam int unsigned EW   = 13;
  localparam int unsigned TAGW = 4;

  typedef struct {
    logic [W-1:0]    fn;
    logic [EW-1:0]   en;
    logic [TAGW-1:0] tag;
    logic            zero;
    int              cyc;
    bit              lat;
  } exp_t;

  logic clk;
  logic rst_n;
  norm_shift_if #(.W(W), .EW(EW), .TAGW(TAGW)) bus ();

  norm_shift #(.W(W), .EW(EW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   chk_lat  = 0;
  bit   or_mode  = 0;
  bit   or_fixed = 1;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: shift by the signed distance as plain arithmetic on the whole value.
  function automatic exp_t model(input logic [W-1:0] fr, input logic [EW-1:0] er,
                                 input logic [EW-1:0] sh, input logic [TAGW-1:0] tag);
    exp_t e;
    int s, k;
    logic [W-1:0] qt, rem;
    s = int'($signed(sh));
    if (s >= 0) begin
      k = s;
      if (k >= int'(W)) e.fn = '0;
      else e.fn = fr << k;
    end else begin
      k = -s;
      if (k >= int'(W)) begin
        e.fn = '0;
        e.fn[0] = (fr != '0);
      end else begin
        qt  = fr >> k;
        rem = fr - (qt << k);
        e.fn = qt;
        if (rem != '0) e.fn[0] = 1'b1;
      end
    end
    e.en   = EW'(er - sh);
    e.tag  = tag;
    e.zero = (e.fn == '0);
    e.cyc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  // out_ready driver: fixed level or random 50%.
  always @(posedge clk) begin
    #1;
    bus.out_ready = or_mode ? 1'($urandom % 2) : or_fixed;
  end

  // Monitor: check ready, compare presented output with queue head, record accepts.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(q.size() == 2 && !bus.out_ready)));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got out_valid=1 expected no pending op (t=%0t)", $time);
        end else begin
          chk("fn",      64'(bus.fn),      64'(q[0].fn));
          chk("en",      64'(bus.en),      64'(q[0].en));
          chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
          chk("fn_zero", 64'(bus.fn_zero), 64'(q[0].zero));
          if (bus.out_ready) begin
            if (q[0].lat) chk("latency", 64'(cyc - q[0].cyc), 64'd2);
            void'(q.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.fr, bus.er, bus.sh, bus.in_tag);
        e.cyc = cyc;
        e.lat = chk_lat;
        q.push_back(e);
      end
    end
  end

  // Present one op at posedge+1 and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] fr, input logic [EW-1:0] er,
                      input logic [EW-1:0] sh, input logic [TAGW-1:0] tag);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.fr = fr;
    bus.er = er;
    bus.sh = sh;
    bus.in_tag = tag;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  // Wait for the scoreboard to empty (bounded), end at posedge+1.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] rand_sh();
    int m;
    m = int'($urandom_range(0, 2));
    if (m == 0) return EW'($urandom_range(0, 140)) - EW'(70);
    if (m == 1) return EW'($urandom_range(0, 60));
    return EW'($urandom);
  endfunction

  initial begin
    rst_n = 0;
    bus.in_valid = 0;
    bus.fr = '0;
    bus.er = '0;
    bus.sh = '0;
    bus.in_tag = '0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_fn",        64'(bus.fn),        64'd0);
    chk("rst_en",        64'(bus.en),        64'd0);
    chk("rst_tag",       64'(bus.out_tag),   64'd0);
    chk("rst_fn_zero",   64'(bus.fn_zero),   64'd0);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    // Directed boundary cases.
    chk_lat = 1;
    send(56'h1, 13'd100, 13'd55, 4'h1);
    send(56'h1E1, 13'd200, 13'h1FFC, 4'h2);
    send(56'h1E0, 13'd200, 13'h1FFC, 4'h3);
    send(56'h3, 13'd10, 13'h1F9C, 4'h4);           // sh = -100
    send(56'h0, 13'd10, 13'h1F9C, 4'h5);
    send(56'hFF, 13'd7, 13'd60, 4'h6);
    send(56'h8000_0000_0001, 13'd50, 13'h1000, 4'h7);
    send(56'hAB_CDEF_0123_4567, 13'd3, 13'd0, 4'h8);
    send(56'h0, 13'd3, 13'd5, 4'h9);
    send(56'hFF_FFFF_FFFF_FFFF, 13'h0FFF, 13'h1FC9, 4'hA);  // sh = -55
    send(56'hFF_FFFF_FFFF_FFFF, 13'h0FFF, 13'h1FC8, 4'hB);  // sh = -56
    drain();

    // Full throughput: 10 back-to-back ops with out_ready held high.
    for (int i = 0; i < 10; i++)
      send(W'({$urandom, $urandom}), EW'($urandom), rand_sh(), TAGW'(i));
    drain();
    chk_lat = 0;

    // Random back-pressure.
    or_mode = 1;
    for (int i = 0; i < 16; i++)
      send(W'({$urandom, $urandom}), EW'($urandom), rand_sh(), TAGW'($urandom));
    drain();
    or_mode = 0;

    // Reset with two ops in flight.
    or_fixed = 0;
    @(posedge clk);
    #1;
    send(56'h1234, 13'd1, 13'd4, 4'hC);
    send(56'h5678, 13'd2, 13'h1FFE, 4'hD);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_fn",        64'(bus.fn),        64'd0);
    q.delete();
    or_fixed = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    chk_lat = 1;
    send(56'h2, 13'd20, 13'd3, 4'hE);
    drain();
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
